// File: rtl/led_shifter_pkg.sv
// Shared constants and state encoding for the framebuffer-to-LED-chain path.
package led_shifter_pkg;

    localparam int c_ledboards = 30;
    localparam int c_bpc       = 12;
    localparam int c_channels  = c_ledboards * 32;
    localparam int c_addr_w    = $clog2(c_channels);
    localparam int c_max_time  = 480;
    localparam int c_time_w    = $clog2(c_max_time);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHIFT = 3'd2,
        LATCH = 3'd3,
        GAP   = 3'd4
    } state_t;

    // Width of a down-counter that must hold values 0..n-1 (never narrower than 1).
    function automatic int f_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_shifter_if.sv
// Framebuffer read port as seen by the shifter: address out, word and gap in.
interface led_shifter_if
    import led_shifter_pkg::*;
#(
    parameter int c_aw = c_addr_w
);

    logic [c_aw-1:0]     raddr;
    logic [c_bpc-1:0]    rdata;
    logic [c_time_w-1:0] gap_time;

    modport master (output raddr, input rdata, input gap_time);
    modport slave  (input raddr, output rdata, output gap_time);

endinterface

// File: rtl/led_sclk_gen.sv
// Serial-clock prescaler: c_half cycles low then c_half cycles high, with a
// strobe on the last high cycle. Held low and cleared while disabled.
module led_sclk_gen
    import led_shifter_pkg::*;
#(
    parameter int c_half = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic enable,
    output logic sclk,
    output logic fall
);

    localparam int             c_cw   = f_cnt_w(c_half);
    localparam logic [c_cw-1:0] c_last = c_cw'(c_half - 1);

    logic [c_cw-1:0] cnt_r;
    logic            phase_r;
    logic            end_s;

    assign end_s = enable && (cnt_r == c_last);
    assign fall  = end_s && phase_r;
    assign sclk  = phase_r;

    // Phase counter; restarts at the low phase whenever the enable drops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_r   <= {c_cw{1'b0}};
            phase_r <= 1'b0;
        end else if (!enable) begin
            cnt_r   <= {c_cw{1'b0}};
            phase_r <= 1'b0;
        end else if (end_s) begin
            cnt_r   <= {c_cw{1'b0}};
            phase_r <= !phase_r;
        end else begin
            cnt_r   <= cnt_r + c_cw'(1);
        end
    end

endmodule

// File: rtl/led_shifter.sv
// Frame shift-out engine: reads every channel word in address order, clocks it
// MSB-first into the LED driver chain, latches, then waits the inter-frame gap.
module led_shifter
    import led_shifter_pkg::*;
#(
    parameter int c_boards  = c_ledboards,
    parameter int c_half    = 2,
    parameter int c_lat_len = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    led_shifter_if.master fb,
    output logic          o_sclk,
    output logic          o_sdata,
    output logic          o_lat,
    output logic          o_busy,
    output logic          o_frame_done
);

    localparam int c_nch = c_boards * 32;
    localparam int c_aw  = $clog2(c_nch);
    localparam int c_bw  = f_cnt_w(c_bpc);
    localparam int c_lw  = f_cnt_w(c_lat_len);

    localparam logic [c_aw-1:0] c_last_addr = c_aw'(c_nch - 1);
    localparam logic [c_bw-1:0] c_bit_top   = c_bw'(c_bpc - 1);
    localparam logic [c_lw-1:0] c_lat_top   = c_lw'(c_lat_len - 1);

    state_t              state_r,   state_s;
    logic [c_aw-1:0]     raddr_r,   raddr_s;
    logic [c_bpc-1:0]    shreg_r,   shreg_s;
    logic [c_bw-1:0]     bit_r,     bit_s;
    logic                fetch_r,   fetch_s;
    logic [c_lw-1:0]     lat_cnt_r, lat_cnt_s;
    logic [c_time_w-1:0] gap_r,     gap_s;
    logic                lat_r,     lat_s;
    logic                busy_r,    busy_s;
    logic                done_r,    done_s;
    logic                fall_s;

    led_sclk_gen #(.c_half(c_half)) u_sclk (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .enable (state_r == SHIFT),
        .sclk   (o_sclk),
        .fall   (fall_s)
    );

    // Next-state and next-output logic; the shift register empties itself
    // after the last bit, so o_sdata is naturally 0 outside SHIFT.
    always_comb begin
        state_s   = state_r;
        raddr_s   = raddr_r;
        shreg_s   = shreg_r;
        bit_s     = bit_r;
        fetch_s   = fetch_r;
        lat_cnt_s = lat_cnt_r;
        gap_s     = gap_r;
        lat_s     = lat_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_en) begin
                    state_s = FETCH;
                    raddr_s = {c_aw{1'b0}};
                    fetch_s = 1'b0;
                    busy_s  = 1'b1;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            FETCH: begin
                if (!fetch_r) begin
                    fetch_s = 1'b1;
                end else begin
                    fetch_s = 1'b0;
                    shreg_s = fb.rdata;
                    bit_s   = c_bit_top;
                    state_s = SHIFT;
                end
            end
            SHIFT: begin
                if (fall_s) begin
                    shreg_s = {shreg_r[c_bpc-2:0], 1'b0};
                    if (bit_r != {c_bw{1'b0}}) begin
                        bit_s = bit_r - c_bw'(1);
                    end else if (raddr_r != c_last_addr) begin
                        raddr_s = raddr_r + c_aw'(1);
                        state_s = FETCH;
                    end else begin
                        state_s   = LATCH;
                        lat_s     = 1'b1;
                        lat_cnt_s = c_lat_top;
                        gap_s     = fb.gap_time;
                        done_s    = (c_lat_len == 1);
                    end
                end else begin
                    shreg_s = shreg_r;
                end
            end
            LATCH: begin
                if (lat_cnt_r != {c_lw{1'b0}}) begin
                    lat_cnt_s = lat_cnt_r - c_lw'(1);
                    done_s    = (lat_cnt_r == c_lw'(1));
                end else begin
                    lat_s   = 1'b0;
                    raddr_s = {c_aw{1'b0}};
                    if (gap_r != {c_time_w{1'b0}}) begin
                        state_s = GAP;
                    end else if (i_en) begin
                        state_s = FETCH;
                    end else begin
                        state_s = IDLE;
                        busy_s  = 1'b0;
                    end
                end
            end
            GAP: begin
                // gap_r holds the cycles still to spend here, including this one
                if (gap_r > c_time_w'(1)) begin
                    gap_s = gap_r - c_time_w'(1);
                end else if (i_en) begin
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                lat_s   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame without a latch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r   <= IDLE;
            raddr_r   <= {c_aw{1'b0}};
            shreg_r   <= {c_bpc{1'b0}};
            bit_r     <= {c_bw{1'b0}};
            fetch_r   <= 1'b0;
            lat_cnt_r <= {c_lw{1'b0}};
            gap_r     <= {c_time_w{1'b0}};
            lat_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            raddr_r   <= raddr_s;
            shreg_r   <= shreg_s;
            bit_r     <= bit_s;
            fetch_r   <= fetch_s;
            lat_cnt_r <= lat_cnt_s;
            gap_r     <= gap_s;
            lat_r     <= lat_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign fb.raddr     = raddr_r;
    assign o_sdata      = shreg_r[c_bpc-1];
    assign o_lat        = lat_r;
    assign o_busy       = busy_r;
    assign o_frame_done = done_r;

endmodule

// File: tb/tb_led_shifter.sv
// Bench for led_shifter: one board, c_half=1 (dut1) and c_half=2 (dut2), with
// a timeline model of the expected serial output checked every cycle.
module tb_led_shifter;
    import led_shifter_pkg::*;

    localparam int c_nw  = 32;
    localparam int c_lat = 4;

    logic                clk = 1'b0;
    logic [1:0]          rst;
    logic [1:0]          en;
    logic [c_time_w-1:0] gtime;
    logic [c_bpc-1:0]    mem [c_nw];
    logic [1:0]          sclk_w, sdata_w, lat_w, busy_w, done_w;

    led_shifter_if #(.c_aw(5)) fb1 ();
    led_shifter_if #(.c_aw(5)) fb2 ();

    assign fb1.gap_time = gtime;
    assign fb2.gap_time = gtime;
    always @(posedge clk) fb1.rdata <= mem[fb1.raddr];
    always @(posedge clk) fb2.rdata <= mem[fb2.raddr];
    always #5 clk = ~clk;

    led_shifter #(.c_boards(1), .c_half(1), .c_lat_len(c_lat)) dut1 (
        .i_clk(clk), .i_rst(rst[0]), .i_en(en[0]), .fb(fb1),
        .o_sclk(sclk_w[0]), .o_sdata(sdata_w[0]), .o_lat(lat_w[0]),
        .o_busy(busy_w[0]), .o_frame_done(done_w[0]));

    led_shifter #(.c_boards(1), .c_half(2), .c_lat_len(c_lat)) dut2 (
        .i_clk(clk), .i_rst(rst[1]), .i_en(en[1]), .fb(fb2),
        .o_sclk(sclk_w[1]), .o_sdata(sdata_w[1]), .o_lat(lat_w[1]),
        .o_busy(busy_w[1]), .o_frame_done(done_w[1]));

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int mode [2];
    int t_off [2];
    int gap_v [2];
    int rises [2], lat_cyc [2], done_cnt [2], busy_cyc [2], busy_drops [2];
    int gap_meas [2], lat_fall [2], max_addr [2];
    bit gap_pend [2];
    logic p_sclk [2], p_lat [2], p_busy [2];
    logic q0 [$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic int hv(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int shift_len(input int d);
        return c_nw * (2 + 2 * c_bpc * hv(d));
    endfunction

    // Expected outputs from the frame offset: word w occupies 2 fetch cycles
    // then c_bpc bits of (h low + h high) cycles; latch and gap follow.
    function automatic void model_out(input int d, output int es, output int ed,
                                      output int el, output int eb, output int ef,
                                      output int ea);
        int h, p, w, rr, b;
        h = hv(d);
        p = 2 + 2 * c_bpc * h;
        es = 0; ed = 0; el = 0; eb = 0; ef = 0; ea = 0;
        if (rst[d] == 1'b0 && mode[d] == 1) begin
            eb = 1;
            if (t_off[d] < shift_len(d)) begin
                w  = t_off[d] / p;
                rr = t_off[d] % p;
                ea = w;
                if (rr >= 2) begin
                    b  = (rr - 2) / (2 * h);
                    es = (((rr - 2) % (2 * h)) >= h) ? 1 : 0;
                    ed = int'(mem[w][c_bpc-1-b]);
                end
            end else if (t_off[d] < shift_len(d) + c_lat) begin
                ea = c_nw - 1;
                el = 1;
                ef = (t_off[d] == shift_len(d) + c_lat - 1) ? 1 : 0;
            end
        end
    endfunction

    function automatic int raddr_of(input int d);
        return (d == 0) ? int'(fb1.raddr) : int'(fb2.raddr);
    endfunction

    // Model timeline: advance each frame offset on every clock edge.
    initial begin
        for (int d = 0; d < 2; d++) begin
            mode[d] = 0; t_off[d] = 0; gap_v[d] = 0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst[d]) begin
                    mode[d] = 0;
                end else if (mode[d] == 0) begin
                    if (en[d]) begin
                        mode[d] = 1; t_off[d] = 0;
                    end
                end else begin
                    t_off[d]++;
                    if (t_off[d] == shift_len(d)) gap_v[d] = int'(gtime);
                    if (t_off[d] > shift_len(d) && t_off[d] == shift_len(d) + c_lat + gap_v[d]) begin
                        if (en[d]) t_off[d] = 0;
                        else mode[d] = 0;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model plus event monitors.
    initial begin
        int es, ed, el, eb, ef, ea, a;
        for (int d = 0; d < 2; d++) begin
            rises[d] = 0; lat_cyc[d] = 0; done_cnt[d] = 0; busy_cyc[d] = 0;
            busy_drops[d] = 0; gap_meas[d] = 0; lat_fall[d] = 0; max_addr[d] = 0;
            gap_pend[d] = 1'b0; p_sclk[d] = 1'b0; p_lat[d] = 1'b0; p_busy[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                model_out(d, es, ed, el, eb, ef, ea);
                a = raddr_of(d);
                chk($sformatf("d%0d.sclk c%0d", d, cyc), int'(sclk_w[d]), es);
                if (es == 1) chk($sformatf("d%0d.sdata c%0d", d, cyc), int'(sdata_w[d]), ed);
                if (el == 1 || eb == 0) chk($sformatf("d%0d.sdata0 c%0d", d, cyc), int'(sdata_w[d]), 0);
                chk($sformatf("d%0d.lat c%0d", d, cyc), int'(lat_w[d]), el);
                chk($sformatf("d%0d.busy c%0d", d, cyc), int'(busy_w[d]), eb);
                chk($sformatf("d%0d.done c%0d", d, cyc), int'(done_w[d]), ef);
                chk($sformatf("d%0d.raddr c%0d", d, cyc), a, ea);
                if (a > max_addr[d]) max_addr[d] = a;
                if (sclk_w[d] && !p_sclk[d]) begin
                    rises[d]++;
                    if (d == 0) q0.push_back(sdata_w[d]);
                    if (gap_pend[d]) begin
                        gap_meas[d] = cyc - lat_fall[d] - 3;
                        gap_pend[d] = 1'b0;
                    end
                end
                if (lat_w[d]) lat_cyc[d]++;
                if (!lat_w[d] && p_lat[d]) begin
                    lat_fall[d] = cyc; gap_pend[d] = 1'b1;
                end
                if (done_w[d]) done_cnt[d]++;
                if (busy_w[d]) busy_cyc[d]++;
                if (!busy_w[d] && p_busy[d]) busy_drops[d]++;
                p_sclk[d] = sclk_w[d]; p_lat[d] = lat_w[d]; p_busy[d] = busy_w[d];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts(input int d);
        rises[d] = 0; lat_cyc[d] = 0; done_cnt[d] = 0; busy_cyc[d] = 0; busy_drops[d] = 0;
        if (d == 0) q0.delete();
    endtask

    task automatic pulse_en(input int d);
        en[d] = 1'b1;
        tick(1);
        en[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d, input int budget, input string nm);
        int k;
        k = 0;
        while (busy_w[d] == 1'b0 && k < 20) begin tick(1); k++; end
        k = 0;
        while (busy_w[d] == 1'b1 && k < budget) begin tick(1); k++; end
        chk({nm, " back to idle"}, int'(busy_w[d]), 0);
    endtask

    task automatic wait_done(input int d, input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (done_cnt[d] < n && k < budget) begin tick(1); k++; end
        chk({nm, " frame_done count"}, done_cnt[d], n);
    endtask

    function automatic int q0_word(input int w);
        int v;
        v = 0;
        for (int b = 0; b < c_bpc; b++) v = (v << 1) | int'(q0[w * c_bpc + b]);
        return v;
    endfunction

    function automatic int q0_ones_from(input int first);
        int n;
        n = 0;
        for (int i = first; i < q0.size(); i++) n += int'(q0[i]);
        return n;
    endfunction

    initial begin
        int bad;
        rst = 2'b11; en = 2'b00; gtime = '0;
        for (int i = 0; i < c_nw; i++) mem[i] = '0;
        tick(3);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset d%0d sclk", d), int'(sclk_w[d]), 0);
            chk($sformatf("reset d%0d lat", d), int'(lat_w[d]), 0);
            chk($sformatf("reset d%0d busy", d), int'(busy_w[d]), 0);
            chk($sformatf("reset d%0d raddr", d), raddr_of(d), 0);
        end
        rst = 2'b00;
        tick(2);

        // c_half=2: single frame, word0=7FF
        mem[0] = 12'h7FF;
        clear_counts(1);
        pulse_en(1);
        wait_idle(1, 3000, "h2 frame");
        chk("h2 frame length", busy_cyc[1], 1604);
        chk("h2 sclk rises", rises[1], 384);
        chk("h2 lat cycles", lat_cyc[1], 4);
        chk("h2 frame_done pulses", done_cnt[1], 1);

        // c_half=1: single frame, word0=7FF
        clear_counts(0);
        pulse_en(0);
        wait_idle(0, 2000, "s1 frame");
        chk("s1 frame length", busy_cyc[0], 836);
        chk("s1 sclk rises", rises[0], 384);
        chk("s1 bit count", q0.size(), 384);
        if (q0.size() >= c_bpc) chk("s1 first word bits", q0_word(0), 12'h7FF);
        chk("s1 trailing ones", q0_ones_from(c_bpc), 0);
        chk("s1 lat cycles", lat_cyc[0], 4);

        // address/data ordering: word n = n
        for (int i = 0; i < c_nw; i++) mem[i] = 12'(i);
        clear_counts(0);
        max_addr[0] = 0;
        pulse_en(0);
        wait_idle(0, 2000, "s2 frame");
        chk("s2 bit count", q0.size(), 384);
        bad = 0;
        if (q0.size() == 384)
            for (int w = 0; w < c_nw; w++) if (q0_word(w) != w) bad++;
        chk("s2 words out of order", bad, 0);
        if (q0.size() == 384) chk("s2 word 5", q0_word(5), 5);
        chk("s2 highest address", max_addr[0], 31);

        // gap of 5 with i_en held high
        for (int i = 0; i < c_nw; i++) mem[i] = '0;
        mem[0] = 12'h7FF;
        gtime = 9'd5;
        clear_counts(0);
        gap_pend[0] = 1'b0;
        en[0] = 1'b1;
        tick(2);
        busy_drops[0] = 0;
        wait_done(0, 2, 2500, "s3");
        tick(10);
        chk("s3 gap cycles", gap_meas[0], 5);
        chk("s3 busy drops", busy_drops[0], 0);

        // drop i_en mid-frame: frame still completes with latch and gap
        tick(190);
        done_cnt[0] = 0; lat_cyc[0] = 0;
        en[0] = 1'b0;
        wait_idle(0, 2000, "s4 frame");
        chk("s4 frame_done pulses", done_cnt[0], 1);
        chk("s4 lat cycles", lat_cyc[0], 4);
        rises[0] = 0;
        tick(100);
        chk("s4 sclk after idle", rises[0], 0);
        chk("s4 busy after idle", int'(busy_w[0]), 0);

        // asynchronous reset in the middle of SHIFT
        gtime = '0;
        en[0] = 1'b1;
        tick(100);
        lat_cyc[0] = 0;
        @(posedge clk);
        #3;
        rst[0] = 1'b1;
        #1;
        chk("s5 sclk in reset", int'(sclk_w[0]), 0);
        chk("s5 sdata in reset", int'(sdata_w[0]), 0);
        chk("s5 lat in reset", int'(lat_w[0]), 0);
        chk("s5 busy in reset", int'(busy_w[0]), 0);
        chk("s5 done in reset", int'(done_w[0]), 0);
        chk("s5 raddr in reset", raddr_of(0), 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst[0] = 1'b0;
        chk("s5 no latch on abort", lat_cyc[0], 0);
        clear_counts(0);
        tick(3);
        en[0] = 1'b0;
        wait_idle(0, 2000, "s5 frame");
        chk("s5 sclk rises", rises[0], 384);
        chk("s5 frame length", busy_cyc[0], 836);
        if (q0.size() >= c_bpc) chk("s5 starts at word 0", q0_word(0), 12'h7FF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog timeout");
    end

endmodule
